universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised universal shift register: the next generation of the team's serial shift register. It adds a parallel load, left/right direction, arithmetic right shift, a parallel output and a shift counter with a one-cycle `done` pulse. It serialises and deserialises operands around the adder datapath: load a word, shift it out bit-serially, and flag when a full word has been shifted.

## Interface
- `WIDTH`, default 8: register width in bits; legal range is WIDTH ≥ 2.
- `CW`, default `$clog2(WIDTH+1)`: counter width. Derived; do not override.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `shift` input 1: shift enable.
- `load` input 1: parallel load enable; has priority over `shift`.
- `dir` input 1: shift direction; 0 = right (toward bit 0), 1 = left (toward bit WIDTH-1).
- `arith` input 1: when 1 and `dir`=0, the vacated MSB is filled with the old `q[WIDTH-1]` instead of `in`; ignored when `dir`=1.
- `in` input 1: serial data in.
- `pdata` input WIDTH: parallel load data.
- `out` output 1: serial data out; combinational from `q` and `dir`.
- `q` output WIDTH: register contents.
- `count` output CW: number of shifts since the last load or reset; saturates at WIDTH.
- `done` output 1: registered one-cycle pulse marking the WIDTH-th shift.

## Operation
- Priority at each rising edge: `reset` (asynchronous), then `load`, then `shift`, then hold.
- **Load:**
  - q ← pdata.
  - count ← 0.
  - done ← 0.
  - `shift` is ignored in the same cycle.
- **Shift right** (`dir`=0):
  - q ← {fill, q[WIDTH-1:1]}.
  - fill = q[WIDTH-1] if `arith`=1, else `in`.
- **Shift left** (`dir`=1):
  - q ← {q[WIDTH-2:0], in}.
  - Zero/serial fill only; `arith` has no effect.
- **Serial output:**
  - out = q[0] when `dir`=0.
  - out = q[WIDTH-1] when `dir`=1.
  - `out` follows `dir` combinationally; no extra register.
- **Counter:**
  - Each accepted shift increments `count` if count < WIDTH.
  - At count == WIDTH, shifting continues; `count` stays at WIDTH.
- **done:**
  - Set at the edge where `count` goes from WIDTH-1 to WIDTH.
  - Cleared at the next edge, unconditionally.
  - Never reasserted until a load or reset has cleared `count`.
- **Hold:** with `load`=0 and `shift`=0, q and count hold and done ← 0.
- **Reset:**
  - Asserting `reset` immediately forces q = 0, count = 0, done = 0, with no clock edge needed.
  - `out` therefore reads 0.
  - State stays at these values while `reset` is high.
  - The first update is on the first rising edge after deassertion.

## Timing
- Latency: `q`, `count` and `done` reflect inputs sampled at a rising edge, immediately after that edge; one-cycle latency.
- `out` changes in the same cycle as `q` or `dir`.
- A bit presented on `in` during a right shift appears on `out` after WIDTH shifts. For arith=0, serial in-to-out latency is WIDTH enabled cycles.
- `done` is high for exactly one clk period, aligned with count == WIDTH first becoming true.
- Direction changes mid-word are legal:
  - `count` keeps counting shifts regardless of direction.
  - Bits shift back the other way.
- Reset mid-operation (any count value) aborts the word; no `done` is produced for it.
- `load` and `shift` in the same cycle: load wins, count = 0, no shift occurs.

## Test plan
All scenarios use WIDTH=8.
1. **Reset:** pulse `reset` between clock edges. Required: q=0x00, out=0, count=0, done=0 before the next edge.
2. **Serialise right:**
   - Stimulus: load 0xA5; dir=0, arith=0, in=0; 8 shifts.
   - `out` before each edge: 1,0,1,0,0,1,0,1.
   - Final q=0x00, count=8.
   - `done` high only in the cycle after the 8th shift.
   - Two further shifts leave count=8 with done=0.
3. **Left shift:**
   - Load 0x81, dir=1: out=1.
   - One shift with in=1: q=0x03, out=0, count=1.
4. **Arithmetic right:**
   - Load 0x90; dir=0, arith=1, in=0; 2 shifts.
   - q=0xC8, then q=0xE4.
   - Repeat with arith=0: q=0x48, then q=0x24.
5. **Load/shift collision:**
   - After 5 shifts (count=5), assert load=1 and shift=1 with pdata=0x3C.
   - Required: q=0x3C, count=0, done=0.
   - 8 further shifts produce exactly one `done` pulse.
6. **Reset mid-word:**
   - At count=3, assert `reset` asynchronously mid-cycle.
   - q=0 and count=0 immediately.
   - After release, no `done` appears until 8 new shifts.

Source files
------------

// File: rtl/universal_shift_register.sv
// Purpose : universal shift register with parallel load, bidirectional and arithmetic shift, shift counter and done pulse.
// Latency : q/count/done update one cycle after the sampling edge; out is combinational from q and dir.
// Backpres: none; load and shift are accepted every cycle (load wins over shift).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (q, count, done -> 0)
//   shift  - shift enable
//   load   - parallel load enable, priority over shift
//   dir    - 0 = shift right (toward bit 0), 1 = shift left (toward MSB)
//   arith  - right shifts refill the MSB with the old sign bit instead of in
//   in     - serial data in
//   pdata  - parallel load data
//   out    - serial data out: q[0] when shifting right, q[WIDTH-1] when left
//   q      - register contents
//   count  - shifts since the last load/reset, saturating at WIDTH
//   done   - one-cycle pulse on the shift that brings count to WIDTH
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             load,
    input  logic             dir,
    input  logic             arith,
    input  logic             in,
    input  logic [WIDTH-1:0] pdata,
    output logic             out,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    count,
    output logic             done
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    logic             fill_bit;
    logic [WIDTH-1:0] q_shifted;

    // Right shifts replicate the sign bit in arithmetic mode; left shifts
    // always take the serial input.
    always_comb begin
        fill_bit  = arith ? q[WIDTH-1] : in;
        q_shifted = q;
        if (dir) begin
            q_shifted = {q[WIDTH-2:0], in};
        end else begin
            q_shifted = {fill_bit, q[WIDTH-1:1]};
        end
    end

    assign out = dir ? q[WIDTH-1] : q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            q     <= pdata;
            count <= '0;
            done  <= 1'b0;
        end else if (shift) begin
            q <= q_shifted;
            // Once saturated the counter freezes, so done can only fire on
            // the single WIDTH-1 -> WIDTH transition per word.
            if (count != COUNT_FULL) begin
                count <= count + CW'(1);
            end
            done <= (count == COUNT_LAST);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    logic       clk;
    logic       reset;
    logic       shift;
    logic       load;
    logic       dir;
    logic       arith;
    logic       in_bit;
    logic [7:0] pdata;
    logic       out;
    logic [7:0] q;
    logic [3:0] count;
    logic       done;

    int total;
    int bad;

    universal_shift_register #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .shift (shift),
        .load  (load),
        .dir   (dir),
        .arith (arith),
        .in    (in_bit),
        .pdata (pdata),
        .out   (out),
        .q     (q),
        .count (count),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load  = 1'b1;
        pdata = v;
        step();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_init_q got=%h want=00", q); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_init_count got=%0d want=0", count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b want=0", done); end
        do_load(8'hFF);
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL rst_preload_q got=%h want=ff", q); end
        total++; if (out !== 1'b1) begin bad++; $display("FAIL rst_preload_out got=%b want=1", out); end
        #2 reset = 1'b1;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_async_q got=%h want=00", q); end
        total++; if (out !== 1'b0) begin bad++; $display("FAIL rst_async_out got=%b want=0", out); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_async_count got=%0d want=0", count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_async_done got=%b want=0", done); end
        #1 reset = 1'b0;
        step();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_hold_q got=%h want=00", q); end
    endtask

    task automatic test_serialise_right();
        logic exp_out [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_load(8'hA5);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL ser_load_count got=%0d want=0", count); end
        dir = 1'b0; arith = 1'b0; in_bit = 1'b0; shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (out !== exp_out[i]) begin bad++; $display("FAIL ser_out[%0d] got=%b want=%b", i, out, exp_out[i]); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL ser_done_early[%0d] got=%b want=0", i, done); end
            step();
        end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL ser_final_q got=%h want=00", q); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ser_final_count got=%0d want=8", count); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ser_done_pulse got=%b want=1", done); end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (count !== 4'd8) begin bad++; $display("FAIL ser_sat_count[%0d] got=%0d want=8", i, count); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL ser_sat_done[%0d] got=%b want=0", i, done); end
        end
        shift = 1'b0;
    endtask

    task automatic test_left();
        dir = 1'b1;
        do_load(8'h81);
        total++; if (out !== 1'b1) begin bad++; $display("FAIL left_out_load got=%b want=1", out); end
        in_bit = 1'b1; shift = 1'b1;
        step();
        shift = 1'b0; in_bit = 1'b0;
        total++; if (q !== 8'h03) begin bad++; $display("FAIL left_q got=%h want=03", q); end
        total++; if (out !== 1'b0) begin bad++; $display("FAIL left_out got=%b want=0", out); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL left_count got=%0d want=1", count); end
        // out follows dir combinationally: switching to right shows q[0]
        dir = 1'b0;
        #1;
        total++; if (out !== 1'b1) begin bad++; $display("FAIL left_dir_out got=%b want=1", out); end
    endtask

    task automatic test_arith();
        dir = 1'b0; in_bit = 1'b0; arith = 1'b1;
        do_load(8'h90);
        shift = 1'b1;
        step();
        total++; if (q !== 8'hC8) begin bad++; $display("FAIL arith1_q1 got=%h want=c8", q); end
        step();
        total++; if (q !== 8'hE4) begin bad++; $display("FAIL arith1_q2 got=%h want=e4", q); end
        shift = 1'b0; arith = 1'b0;
        do_load(8'h90);
        shift = 1'b1;
        step();
        total++; if (q !== 8'h48) begin bad++; $display("FAIL arith0_q1 got=%h want=48", q); end
        step();
        total++; if (q !== 8'h24) begin bad++; $display("FAIL arith0_q2 got=%h want=24", q); end
        shift = 1'b0;
        // arith is ignored on left shifts
        dir = 1'b1; arith = 1'b1;
        do_load(8'h90);
        shift = 1'b1;
        step();
        shift = 1'b0; arith = 1'b0; dir = 1'b0;
        total++; if (q !== 8'h20) begin bad++; $display("FAIL arith_left_q got=%h want=20", q); end
    endtask

    task automatic test_dir_change();
        do_load(8'h01);
        dir = 1'b1; in_bit = 1'b0; shift = 1'b1;
        step();
        step();
        total++; if (q !== 8'h04) begin bad++; $display("FAIL dirchg_left_q got=%h want=04", q); end
        dir = 1'b0;
        step();
        shift = 1'b0;
        total++; if (q !== 8'h02) begin bad++; $display("FAIL dirchg_right_q got=%h want=02", q); end
        total++; if (count !== 4'd3) begin bad++; $display("FAIL dirchg_count got=%0d want=3", count); end
        step();
        total++; if (q !== 8'h02 || count !== 4'd3) begin bad++; $display("FAIL hold got=%h/%0d want=02/3", q, count); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        dir = 1'b0; arith = 1'b0; in_bit = 1'b0;
        do_load(8'hFF);
        shift = 1'b1;
        repeat (5) step();
        total++; if (count !== 4'd5) begin bad++; $display("FAIL coll_pre_count got=%0d want=5", count); end
        load = 1'b1; pdata = 8'h3C;
        step();
        load = 1'b0;
        total++; if (q !== 8'h3C) begin bad++; $display("FAIL coll_q got=%h want=3c", q); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL coll_count got=%0d want=0", count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL coll_done got=%b want=0", done); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL coll_done_8th got=%b want=1", done); end
        shift = 1'b0;
        step();
        if (done === 1'b1) pulses++;
        total++; if (pulses != 1) begin bad++; $display("FAIL coll_pulses got=%0d want=1", pulses); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL coll_final_q got=%h want=00", q); end
    endtask

    task automatic test_reset_mid();
        int early;
        dir = 1'b0; arith = 1'b0; in_bit = 1'b1;
        do_load(8'h5A);
        shift = 1'b1;
        repeat (3) step();
        total++; if (count !== 4'd3) begin bad++; $display("FAIL rmid_pre_count got=%0d want=3", count); end
        #2 reset = 1'b1;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rmid_q got=%h want=00", q); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
        step();
        total++; if (q !== 8'h00 || count !== 4'd0) begin bad++; $display("FAIL rmid_held got=%h/%0d want=00/0", q, count); end
        reset = 1'b0;
        early = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (done !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL rmid_early_done got=%0d want=0", early); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL rmid_count7 got=%0d want=7", count); end
        step();
        shift = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b want=1", done); end
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL rmid_q_ff got=%h want=ff", q); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; shift = 1'b0; load = 1'b0; dir = 1'b0;
        arith = 1'b0; in_bit = 1'b0; pdata = 8'h00;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_serialise_right();
        test_left();
        test_arith();
        test_dir_change();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
